// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - issue/stall sequencer for the shared iterative multiply/divide unit
// Optional macro MULDIV_PERF_EN adds stall-cycle and retired-op performance counters.
module muldiv_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 100
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                validE,
  input  logic                mulE,
  input  logic                divE,
  input  logic                signedE,
  input  logic [DATA_W-1:0]   srcaE,
  input  logic [DATA_W-1:0]   srcbE,
  input  logic                flush_i,
  input  logic                stall_ext_i,
  output logic                unit_start_o,
  output logic                unit_op_o,
  output logic                unit_signed_o,
  output logic [DATA_W-1:0]   unit_a_o,
  output logic [DATA_W-1:0]   unit_b_o,
  output logic                unit_cancel_o,
  input  logic                unit_done_i,
  input  logic [2*DATA_W-1:0] unit_result_i,
  output logic                stall_o,
  output logic                hilo_we_o,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic                busy_o,
`ifdef MULDIV_PERF_EN
  output logic [31:0]         perf_busy_o,
  output logic [31:0]         perf_ops_o,
`endif
  output logic                err_timeout_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] result_q;
  logic                issue;
  logic                div_zero;

  assign issue    = validE & (mulE | divE) & ~flush_i & ~stall_ext_i;
  // divE wins when both decode bits are set, so the zero check keys off divE alone
  assign div_zero = divE & (srcbE == '0);

  assign hilo_o = result_q;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    hilo_we_o     = 1'b0;
    unit_cancel_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          stall_o = 1'b1;
          state_d = div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          unit_cancel_o = 1'b1;
          state_d       = IDLE;
        end else if (unit_done_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!stall_ext_i) begin
          hilo_we_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      result_q      <= '0;
      unit_start_o  <= 1'b0;
      unit_op_o     <= 1'b0;
      unit_signed_o <= 1'b0;
      unit_a_o      <= '0;
      unit_b_o      <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_start_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            unit_op_o     <= divE;
            unit_signed_o <= signedE;
            unit_a_o      <= srcaE;
            unit_b_o      <= srcbE;
            unit_start_o  <= ~div_zero;
            cnt_q         <= '0;
            // a divide by zero retires this zero result without touching the unit
            result_q      <= '0;
          end
        end
        RUN: begin
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          if (!flush_i && unit_done_i) begin
            result_q <= unit_result_i;
          end else if (!unit_done_i && (cnt_q >= CNT_W'(TIMEOUT - 1))) begin
            err_timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_busy_o <= '0;
      perf_ops_o  <= '0;
    end else begin
      if (stall_o)   perf_busy_o <= perf_busy_o + 32'd1;
      if (hilo_we_o) perf_ops_o  <= perf_ops_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - self-checking bench for muldiv_issue_ctrl
module tb_muldiv_issue_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic           validE, mulE, divE, signedE;
  logic [W-1:0]   srcaE, srcbE;
  logic           flush_i, stall_ext_i, unit_done_i;
  logic [2*W-1:0] unit_result_i;
  logic           unit_start_o, unit_op_o, unit_signed_o, unit_cancel_o;
  logic [W-1:0]   unit_a_o, unit_b_o;
  logic           stall_o, hilo_we_o, busy_o, err_timeout_o;
  logic [2*W-1:0] hilo_o;

  muldiv_issue_ctrl dut (
    .clk(clk), .resetn(resetn), .validE(validE), .mulE(mulE), .divE(divE),
    .signedE(signedE), .srcaE(srcaE), .srcbE(srcbE), .flush_i(flush_i),
    .stall_ext_i(stall_ext_i), .unit_start_o(unit_start_o), .unit_op_o(unit_op_o),
    .unit_signed_o(unit_signed_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_cancel_o(unit_cancel_o), .unit_done_i(unit_done_i),
    .unit_result_i(unit_result_i), .stall_o(stall_o), .hilo_we_o(hilo_we_o),
    .hilo_o(hilo_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          m, d, s;
    logic [31:0] a, b;
    int          lat, hold;
    logic [63:0] exp;
    int          exp_stall;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, nstart = 0, ncancel = 0, nstall = 0, nwe = 0, we_cyc = 0;
  int ucnt = 0, ulat = 4;
  bit advanced = 0, force_done = 0, s_busy = 0, s_err = 0, s_cancel = 0;
  logic [63:0] whilo = '0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Architectural HI/LO result: HI = high product / remainder, LO = low product / quotient
  function automatic logic [63:0] ref_calc(input bit d, input bit s, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (d) begin
      if (b == 32'd0) return 64'd0;
      if (s) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
    end
    if (s) return 64'(sa * sb);
    return ua * ub;
  endfunction

  function automatic vec_t mk(input string nm, input bit m, input bit d, input bit s,
                              input logic [31:0] a, input logic [31:0] b, input int lat,
                              input int hold, input logic [63:0] exp, input int exp_stall);
    vec_t v;
    v.nm = nm; v.m = m; v.d = d; v.s = s; v.a = a; v.b = b;
    v.lat = lat; v.hold = hold; v.exp = exp; v.exp_stall = exp_stall;
    return v;
  endfunction

  // One pipeline cycle: unit model drives done, outputs sampled mid-cycle, then the edge.
  task automatic tick();
    unit_done_i = 1'b0;
    if (force_done) begin
      unit_done_i = 1'b1;
      force_done  = 1'b0;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        unit_done_i   = 1'b1;
        unit_result_i = ref_calc(unit_op_o, unit_signed_o, unit_a_o, unit_b_o);
      end
    end
    #2;
    s_busy   = busy_o;
    s_err    = err_timeout_o;
    s_cancel = unit_cancel_o;
    if (unit_start_o) begin nstart++; ucnt = ulat - 1; end
    if (unit_cancel_o) begin ncancel++; ucnt = 0; end
    if (stall_o) nstall++;
    if (hilo_we_o) begin nwe++; we_cyc = cyc; whilo = hilo_o; end
    if (validE && !stall_o && !stall_ext_i) advanced = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input bit post);
    int iss, dcyc, st0, we0, s0;
    bit dz;
    ulat = v.lat;
    st0 = nstall; we0 = nwe; s0 = nstart;
    dz = v.d && (v.b == 32'd0);
    iss = cyc;
    dcyc = iss + (dz ? 1 : v.lat + 1);
    validE = 1'b1; mulE = v.m; divE = v.d; signedE = v.s; srcaE = v.a; srcbE = v.b;
    advanced = 1'b0;
    for (int k = 0; k < v.lat + v.hold + 20 && !advanced; k++) begin
      stall_ext_i = (cyc >= dcyc) && (cyc < dcyc + v.hold);
      tick();
    end
    validE = 1'b0; mulE = 1'b0; divE = 1'b0; stall_ext_i = 1'b0;
    chk_int({v.nm, " advanced"}, int'(advanced), 1);
    chk_int({v.nm, " we_count"}, nwe - we0, 1);
    chk({v.nm, " hilo"}, whilo, v.exp);
    chk_int({v.nm, " we_cycle"}, we_cyc - iss, dcyc + v.hold - iss);
    chk_int({v.nm, " stall_cycles"}, nstall - st0, v.exp_stall);
    chk_int({v.nm, " starts"}, nstart - s0, dz ? 0 : 1);
    if (post) begin
      tick();
      chk_int({v.nm, " busy_after"}, int'(s_busy), 0);
      chk_int({v.nm, " no_reissue"}, nwe - we0, 1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ctrl"}, 64'({unit_start_o, unit_op_o, unit_signed_o, unit_cancel_o,
                             stall_o, hilo_we_o, busy_o, err_timeout_o}), 64'd0);
    chk({tag, " operands"}, {unit_a_o, unit_b_o}, 64'd0);
    chk({tag, " hilo"}, hilo_o, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m, d, s;
    logic [31:0] a, b;
    int lat, hold, c0, s0, w0;

    resetn = 1'b0; validE = 0; mulE = 0; divE = 0; signedE = 0; srcaE = '0; srcbE = '0;
    flush_i = 0; stall_ext_i = 0; unit_done_i = 0; unit_result_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;
    tick();

    tbl[0] = mk("mult_neg",   1, 0, 1, 32'hFFFFFFFD, 32'd7, 4, 0, 64'hFFFFFFFF_FFFFFFEB, 5);
    tbl[1] = mk("divu_100_7", 0, 1, 0, 32'd100, 32'd7, 33, 0, 64'h00000002_0000000E, 34);
    tbl[2] = mk("div_zero",   0, 1, 1, 32'd5, 32'd0, 8, 0, 64'd0, 1);
    tbl[3] = mk("multu_hold", 1, 0, 0, 32'hFFFFFFFF, 32'd2, 6, 3, 64'h00000001_FFFFFFFE, 7);
    tbl[4] = mk("div_neg",    0, 1, 1, 32'hFFFFFFF9, 32'd2, 10, 0, 64'hFFFFFFFF_FFFFFFFD, 11);
    tbl[5] = mk("both_div",   1, 1, 0, 32'd9, 32'd4, 5, 0, 64'h00000001_00000002, 6);
    tbl[6] = mk("divu_zero_hold", 0, 1, 0, 32'd77, 32'd0, 4, 2, 64'd0, 1);
    tbl[7] = mk("mult_min",   1, 0, 1, 32'h80000000, 32'h80000000, 3, 0, 64'h40000000_00000000, 4);
    for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b1);

    // flush in the 10th RUN cycle, then a late done that must be ignored
    ulat = 40; c0 = ncancel; s0 = nstart; w0 = nwe;
    validE = 1; mulE = 1; divE = 0; signedE = 0; srcaE = 32'd3; srcbE = 32'd5;
    tick();
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    chk_int("flush cancel_now", int'(s_cancel), 1);
    flush_i = 1'b0; validE = 1'b0; mulE = 1'b0;
    tick();
    chk_int("flush cancel_once", ncancel - c0, 1);
    chk_int("flush idle", int'(s_busy), 0);
    unit_result_i = 64'hDEAD_BEEF;
    force_done = 1'b1;
    tick();
    tick();
    chk_int("flush no_write", nwe - w0, 0);
    chk_int("flush starts", nstart - s0, 1);
    run_op(mk("mult_after_flush", 1, 0, 0, 32'd6, 32'd7, 4, 0, 64'd42, 5), 1'b1);

    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      m = !d || (1'($urandom_range(0, 1)));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      lat = $urandom_range(2, 12);
      hold = $urandom_range(0, 2);
      run_op(mk($sformatf("rnd%0d", i), m, d, s, a, b, lat, hold, ref_calc(d, s, a, b),
                (d && b == 32'd0) ? 1 : lat + 1), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // withheld done: sticky timeout, then async reset mid-RUN
    ulat = 1000;
    validE = 1; mulE = 1; divE = 0; signedE = 1; srcaE = 32'd11; srcbE = 32'd13;
    advanced = 1'b0;
    tick();
    repeat (99) tick();
    tick();
    chk_int("timeout not_yet", int'(s_err), 0);
    tick();
    chk_int("timeout set", int'(s_err), 1);
    repeat (5) tick();
    ucnt = 0; w0 = nwe;
    unit_result_i = 64'h12345678_9ABCDEF0;
    force_done = 1'b1;
    tick();
    tick();
    validE = 1'b0; mulE = 1'b0;
    chk_int("timeout late_write", nwe - w0, 1);
    chk("timeout late_hilo", whilo, 64'h12345678_9ABCDEF0);
    tick();
    chk_int("timeout sticky", int'(s_err), 1);
    validE = 1; divE = 1; signedE = 0; srcaE = 32'd50; srcbE = 32'd3;
    tick();
    validE = 0; divE = 0;
    repeat (3) tick();
    chk_int("midrun busy", int'(s_busy), 1);
    resetn = 1'b0;
    ucnt = 0;
    #1;
    check_zero("midrun_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    chk_int("reset clears err", int'(s_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
